// File: rtl/clint_params.sv
// rtl/clint_params.sv - register map, response codes and helpers for the CLINT
package clint_params;

    localparam logic [15:0] MSIP_OFF     = 16'h0000;
    localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_MSIP,
        REG_MTIMECMP,
        REG_MTIME
    } reg_sel_e;

    // word is addr[15:3]; the byte offset inside a 64-bit word is never decoded
    function automatic reg_sel_e decode_reg(input logic [12:0] word);
        if (word == MSIP_OFF[15:3])          return REG_MSIP;
        else if (word == MTIMECMP_OFF[15:3]) return REG_MTIMECMP;
        else if (word == MTIME_OFF[15:3])    return REG_MTIME;
        else                                 return REG_NONE;
    endfunction

    function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4lite_if.sv
// rtl/axi4lite_if.sv - AXI4-Lite bus with 64-bit data
interface axi4lite #(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [63:0]           wdata;
    logic [7:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [63:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/clint_axi_slave_port.sv
// rtl/clint_axi_slave_port.sv - AXI4-Lite handshake front-end with B/R holding registers
module axi4lite_reg_port
    import clint_params::*;
(
    input  logic        clk,
    input  logic        rst,
    axi4lite.slave      bus,
    output logic        wr_en_o,
    output logic [12:0] wr_addr_o,
    output logic [63:0] wr_data_o,
    output logic [7:0]  wr_strb_o,
    input  logic        wr_err_i,
    output logic        rd_en_o,
    output logic [12:0] rd_addr_o,
    input  logic [63:0] rd_data_i,
    input  logic        rd_err_i
);
    logic        bvalid_q;
    axi_resp_e   bresp_q;
    logic        rvalid_q;
    axi_resp_e   rresp_q;
    logic [63:0] rdata_q;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{bus.awaddr[2:0], bus.araddr[2:0]};

    assign bus.awready = ~bvalid_q;
    assign bus.wready  = ~bvalid_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = ~rvalid_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;

    // AW and W are only taken together, never one without the other
    assign wr_en_o   = bus.awvalid & bus.wvalid & ~bvalid_q;
    assign wr_addr_o = bus.awaddr[15:3];
    assign wr_data_o = bus.wdata;
    assign wr_strb_o = bus.wstrb;
    assign rd_en_o   = bus.arvalid & ~rvalid_q;
    assign rd_addr_o = bus.araddr[15:3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            if (wr_en_o) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err_i ? RESP_DECERR : RESP_OKAY;
            end else if (bus.bready) begin
                bvalid_q <= 1'b0;
            end
            if (rd_en_o) begin
                rvalid_q <= 1'b1;
                rresp_q  <= rd_err_i ? RESP_DECERR : RESP_OKAY;
                rdata_q  <= rd_err_i ? '0 : rd_data_i;
            end else if (bus.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/clint_axi_slave.sv
// rtl/clint_axi_slave.sv - core-local interruptor: msip, mtimecmp, free-running mtime
module clint_axi_slave
    import clint_params::*;
#(
    parameter int          ADDR_WIDTH  = 16,
    parameter int          TICK_DIV    = 1,
    parameter logic [63:0] MTIME_RESET = 64'h0
) (
    input  logic   clk,
    input  logic   rst,
    axi4lite.slave bus,
    output logic   timer_irq,
    output logic   soft_irq
);
    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

    logic        wr_en, rd_en, wr_err, rd_err, tick;
    logic [12:0] wr_addr, rd_addr;
    logic [63:0] wr_data, rd_data;
    logic [7:0]  wr_strb;
    reg_sel_e    wr_sel, rd_sel;

    logic        msip_q, msip_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [63:0] mtime_q, mtime_d;
    logic [15:0] presc_q, presc_d;
    logic        timer_irq_q;

    axi4lite_reg_port u_port (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data),
        .wr_strb_o (wr_strb),
        .wr_err_i  (wr_err),
        .rd_en_o   (rd_en),
        .rd_addr_o (rd_addr),
        .rd_data_i (rd_data),
        .rd_err_i  (rd_err)
    );

    assign wr_sel = decode_reg(wr_addr);
    assign rd_sel = decode_reg(rd_addr);
    assign wr_err = (wr_sel == REG_NONE);
    assign rd_err = (rd_sel == REG_NONE);

    // reads see the register state before this edge's write or tick
    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            case (rd_sel)
                REG_MSIP:     rd_data = {63'b0, msip_q};
                REG_MTIMECMP: rd_data = mtimecmp_q;
                REG_MTIME:    rd_data = mtime_q;
                default:      rd_data = '0;
            endcase
        end
    end

    assign tick = (presc_q == PRESC_LAST);

    // an mtime write overrides the tick; the prescaler keeps running regardless
    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        presc_d    = tick ? 16'd0 : presc_q + 16'd1;
        if (wr_en) begin
            case (wr_sel)
                REG_MSIP:     if (wr_strb[0]) msip_d = wr_data[0];
                REG_MTIMECMP: mtimecmp_d = strb_merge(mtimecmp_q, wr_data, wr_strb);
                REG_MTIME:    mtime_d    = strb_merge(mtime_q, wr_data, wr_strb);
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msip_q      <= 1'b0;
            mtimecmp_q  <= '1;
            mtime_q     <= MTIME_RESET;
            presc_q     <= '0;
            timer_irq_q <= 1'b0;
        end else begin
            msip_q      <= msip_d;
            mtimecmp_q  <= mtimecmp_d;
            mtime_q     <= mtime_d;
            presc_q     <= presc_d;
            timer_irq_q <= (mtime_q >= mtimecmp_q);
        end
    end

    assign timer_irq = timer_irq_q;
    assign soft_irq  = msip_q;
endmodule

// File: tb/tb_clint_axi_slave.sv
// tb/tb_clint_axi_slave.sv - directed self-checking bench for clint_axi_slave
module tb_clint_axi_slave;
    import clint_params::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] awaddr, araddr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        tirq1, sirq1, tirq4, sirq4;
    logic        sel4;

    axi4lite #(.ADDR_WIDTH(16)) bus1 ();
    axi4lite #(.ADDR_WIDTH(16)) bus4 ();

    assign bus1.awaddr = awaddr;  assign bus4.awaddr = awaddr;
    assign bus1.awvalid = awvalid; assign bus4.awvalid = awvalid;
    assign bus1.wdata = wdata;    assign bus4.wdata = wdata;
    assign bus1.wstrb = wstrb;    assign bus4.wstrb = wstrb;
    assign bus1.wvalid = wvalid;  assign bus4.wvalid = wvalid;
    assign bus1.bready = bready;  assign bus4.bready = bready;
    assign bus1.araddr = araddr;  assign bus4.araddr = araddr;
    assign bus1.arvalid = arvalid; assign bus4.arvalid = arvalid;
    assign bus1.rready = rready;  assign bus4.rready = rready;

    clint_axi_slave #(.ADDR_WIDTH(16), .TICK_DIV(1), .MTIME_RESET(64'h0)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .timer_irq(tirq1), .soft_irq(sirq1));
    clint_axi_slave #(.ADDR_WIDTH(16), .TICK_DIV(4), .MTIME_RESET(64'h0)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .timer_irq(tirq4), .soft_irq(sirq4));

    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int n_chk = 0;
    int n_err = 0;
    int acc_cyc;
    logic tirq_at_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // returns at the negedge just before edge 'target' (target 0 = next edge)
    task automatic wait_edge(input int target);
        int n = 0;
        @(negedge clk);
        while (target > 0 && cyc + 1 < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (target > 0) check("align", 64'(cyc + 1), 64'(target));
    endtask

    task automatic do_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s,
                            input int at, output logic [1:0] resp);
        int n = 0;
        wait_edge(at);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!bus1.awready && n < 50) begin @(negedge clk); n++; end
        check("awready", 64'(bus1.awready), 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; acc_cyc = cyc;
        @(negedge clk);
        check("bvalid", 64'(bus1.bvalid), 64'd1);
        resp = sel4 ? bus4.bresp : bus1.bresp;
        tirq_at_b = tirq1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input int at,
                           output logic [63:0] data, output logic [1:0] resp);
        int n = 0;
        wait_edge(at);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!bus1.arready && n < 50) begin @(negedge clk); n++; end
        check("arready", 64'(bus1.arready), 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        check("rvalid", 64'(bus1.rvalid), 64'd1);
        data = sel4 ? bus4.rdata : bus1.rdata;
        resp = sel4 ? bus4.rresp : bus1.rresp;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        logic [1:0]  r;
        int          a0, n, t;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; sel4 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_awready", 64'(bus1.awready), 64'd1);
        check("rst_arready", 64'(bus1.arready), 64'd1);
        check("rst_bvalid", 64'(bus1.bvalid), 64'd0);
        check("rst_rvalid", 64'(bus1.rvalid), 64'd0);
        check("rst_irqs", {62'b0, tirq1, sirq1}, 64'd0);

        // R pending, then asynchronous reset mid-cycle
        araddr = MTIMECMP_OFF; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk); #1 arvalid = 1'b0;
        @(negedge clk);
        check("r_pending", 64'(bus1.rvalid), 64'd1);
        @(posedge clk); #3 rst = 1'b1;
        #1 check("async_rst_rvalid", 64'(bus1.rvalid), 64'd0);
        @(negedge clk) rst = 1'b0;
        do_read(MTIMECMP_OFF, 0, d, r);
        check("rst_mtimecmp", d, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_mtimecmp_resp", 64'(r), 64'(RESP_OKAY));
        check("rst_timer_irq", 64'(tirq1), 64'd0);

        // byte strobes onto all-ones
        do_write(MTIMECMP_OFF, 64'h1122334455667788, 8'h0F, 0, r);
        check("strb_bresp", 64'(r), 64'(RESP_OKAY));
        do_read(MTIMECMP_OFF, 0, d, r);
        check("strb_data", d, 64'hFFFF_FFFF_5566_7788);

        // timer interrupt with TICK_DIV=1
        do_write(MTIME_OFF, 64'd0, 8'hFF, 0, r);
        a0 = acc_cyc;
        do_write(MTIMECMP_OFF, 64'd20, 8'hFF, 0, r);
        n = 0;
        while (cyc < a0 + 20 && n < 100) begin @(negedge clk); n++; end
        check("tirq_at_20", 64'(tirq1), 64'd0);
        @(negedge clk);
        check("tirq_at_21", 64'(tirq1), 64'd1);
        do_write(MTIMECMP_OFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, r);
        check("tirq_before_b", 64'(tirq_at_b), 64'd1);
        @(negedge clk);
        check("tirq_cleared", 64'(tirq1), 64'd0);

        // AW three cycles ahead of W, bready low for four cycles
        @(negedge clk);
        awaddr = MSIP_OFF; wdata = 64'd1; wstrb = 8'hFF; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
        repeat (3) @(negedge clk);
        check("lone_aw_bvalid", 64'(bus1.bvalid), 64'd0);
        check("lone_aw_sirq", 64'(sirq1), 64'd0);
        wvalid = 1'b1;
        @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("ord_sirq", 64'(sirq1), 64'd1);
        check("ord_bvalid", 64'(bus1.bvalid), 64'd1);
        check("ord_awready", 64'(bus1.awready), 64'd0);
        check("ord_bresp", 64'(bus1.bresp), 64'(RESP_OKAY));
        repeat (3) @(negedge clk);
        check("hold_bvalid", 64'(bus1.bvalid), 64'd1);
        check("hold_awready", 64'(bus1.awready), 64'd0);
        bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk);
        check("done_bvalid", 64'(bus1.bvalid), 64'd0);
        check("done_awready", 64'(bus1.awready), 64'd1);

        // msip upper bits read as zero; low address bits ignored
        do_write(MSIP_OFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, r);
        do_read(16'h0004, 0, d, r);
        check("msip_read", d, 64'd1);
        check("msip_resp", 64'(r), 64'(RESP_OKAY));

        // decode errors
        do_read(16'h1000, 0, d, r);
        check("dec_rdata", d, 64'd0);
        check("dec_rresp", 64'(r), 64'(RESP_DECERR));
        do_read(16'hBFF0, 0, d, r);
        check("dec_bff0_rresp", 64'(r), 64'(RESP_DECERR));
        do_write(16'h1000, 64'd0, 8'hFF, 0, r);
        check("dec_bresp", 64'(r), 64'(RESP_DECERR));
        do_read(MSIP_OFF, 0, d, r);
        check("dec_msip_kept", d, 64'd1);
        do_read(MTIMECMP_OFF, 0, d, r);
        check("dec_cmp_kept", d, 64'hFFFF_FFFF_FFFF_FFFF);
        check("dec_sirq_kept", 64'(sirq1), 64'd1);

        // write/tick collision with TICK_DIV=4: ticks land on edges where cyc%4==0
        sel4 = 1'b1;
        t = (cyc / 4 + 2) * 4;
        do_write(MTIME_OFF, 64'h100, 8'hFF, t, r);
        a0 = acc_cyc;
        check("col_edge", 64'(a0 % 4), 64'd0);
        do_read(MTIME_OFF, a0 + 2, d, r);
        check("col_mtime_a2", d, 64'h100);
        do_read(MTIME_OFF, a0 + 4, d, r);
        check("col_mtime_a4", d, 64'h100);
        do_read(MTIME_OFF, a0 + 6, d, r);
        check("col_mtime_a6", d, 64'h101);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/clint_axi_slave.md
Name: clint_axi_slave

Overview:
- AXI4-Lite responder: the other end of the `axi4lite` data bus the core's load/store unit drives as master.
- Implements a core-local interruptor with three registers: msip, mtimecmp and free-running mtime.
- Produces the machine timer and machine software interrupt lines that feed the core's platform interrupt inputs.
- Sits on the uncacheable region of the data bus.

Parameters:
- ADDR_WIDTH, 16: AXI address width. Only addr[15:3] is decoded; addr[2:0] is ignored.
- TICK_DIV, 1: clk cycles per mtime increment. Range 1..65535; 1 means increment every cycle.
- MTIME_RESET, 64'h0: reset value of mtime.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- bus  axi4lite.slave  (interface)  AXI4-Lite channels AW/W/B/AR/R, 64-bit data, 8-bit wstrb, 2-bit resp.
- timer_irq  output  1  machine timer interrupt pending (MTIP).
- soft_irq  output  1  machine software interrupt pending (MSIP).

Behaviour:
- Clocking and reset: one clock domain (clk). rst is asynchronous and active-high.
- Reset values: awready=wready=arready=1; bvalid=rvalid=0; bresp=rresp=0; rdata=0; msip=0; mtimecmp=all ones; mtime=MTIME_RESET; prescaler=0; timer_irq=0; soft_irq=0.
- Reset asserted mid-transaction drops any pending B/R immediately; the master must re-issue.
- Register map (byte offsets, 64-bit aligned):
  - 0x0000 msip: bit0 is R/W; bits 63:1 read 0, writes ignored.
  - 0x4000 mtimecmp: R/W, 64-bit.
  - 0xBFF8 mtime: R/W, 64-bit.
  - All other offsets: read returns 0 with resp DECERR (2'b11); write is dropped with bresp DECERR. Mapped accesses return OKAY (2'b00).
- Write channel (one outstanding write):
  - awready=wready=1 while no B is pending.
  - The write is accepted in the cycle where awvalid && wvalid && awready. AW and W are accepted together; a lone AW or lone W is not accepted and waits for its partner.
  - Register update is applied at that clock edge, per byte lane where wstrb[i]=1.
  - Next cycle: bvalid=1, awready=wready=0. bvalid is held until bready; on the bvalid&&bready edge, bvalid=0 and awready=wready=1.
  - Maximum rate: one write every 2 cycles with bready tied high.
- Read channel (one outstanding read, independent of the write channel):
  - AR is accepted on arvalid&&arready.
  - Next cycle: rvalid=1, arready=0. rdata/rresp are captured from register state before any same-edge write or tick, and held stable until rvalid&&rready.
  - Then arready=1. Maximum rate: one read every 2 cycles.
- Prescaler: counts 0..TICK_DIV-1. The cycle in which it equals TICK_DIV-1 is a tick cycle; the prescaler wraps to 0 and mtime increments by 1 (mod 2^64, wraps from all ones to 0).
- Write/tick collision: an mtime write in a tick cycle wins; merged byte lanes take the written value, and the tick is lost for that cycle. An mtime write does not reset the prescaler.
- Interrupts:
  - timer_irq is registered: timer_irq <= (mtime >= mtimecmp), unsigned, evaluated on the post-update values. It is therefore visible 1 cycle after the mtime or mtimecmp change.
  - soft_irq is the registered msip bit0, visible the cycle after the write edge.
- Simultaneous read and write to the same register in the same cycle: the read returns the old value.

Decomposition:
- Package clint_params:
  - register offset constants: MSIP_OFF, MTIMECMP_OFF, MTIME_OFF;
  - AXI resp enum: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
- Sub-module axi4lite_reg_port: AXI4-Lite handshake front-end (AW/W join, B/R holding registers). It presents wr_en/wr_addr/wr_data/wr_strb and rd_en/rd_addr/rd_data/rd_err to the register core. The register/timer core stays in clint_axi_slave.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle with an R pending -> rvalid=0 immediately. After release: read 0x4000 -> rdata=64'hFFFF_FFFF_FFFF_FFFF, rresp=OKAY; timer_irq=0.
- Timer interrupt, TICK_DIV=1: write mtime=0, then write mtimecmp=20 -> timer_irq rises exactly once mtime reaches 20, plus 1 cycle. Then write mtimecmp=all ones -> timer_irq=0 one cycle after the B handshake edge.
- Byte strobes: write 0x4000 data=64'h1122334455667788 with wstrb=8'h0F onto reset value all ones -> read returns 64'hFFFFFFFF55667788.
- Write channel ordering: AW presented 3 cycles before W, with bready held low for 4 cycles -> no update before W arrives; bvalid stays high with awready=0 until bready; msip=1 gives soft_irq=1 on the cycle after acceptance.
- Decode error: read 0x1000 -> rdata=0, rresp=DECERR. Write 0x1000 -> bresp=DECERR and no register changes.
- Collision, TICK_DIV=4: write mtime=64'h100 on a tick cycle -> subsequent read shows 0x100 (no +1); the next increment occurs 4 cycles later.
